// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Each access runs IDLE -> BUSY (until mem_ack) -> RESP (one-cycle rvalid) -> IDLE.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_i,
    input  logic [63:0] ifu_addr_i,
    output logic        ifu_gnt_o,
    output logic        ifu_rvalid_o,
    output logic [63:0] ifu_rdata_o,

    input  logic        lsu_req_i,
    input  logic [63:0] lsu_addr_i,
    input  logic [5:0]  lsu_ld_type_i,
    input  logic [3:0]  lsu_st_type_i,
    input  logic [63:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [63:0] lsu_rdata_o,

    output logic        mem_req_o,
    output logic [63:0] mem_addr_o,
    output logic [5:0]  mem_ld_type_o,
    output logic [3:0]  mem_st_type_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    state_e      state_q;
    owner_e      owner_q;
    logic        mem_req_q;
    logic [63:0] mem_addr_q;
    logic [5:0]  mem_ld_type_q;
    logic [3:0]  mem_st_type_q;
    logic [63:0] mem_wdata_q;
    logic        ifu_rvalid_q;
    logic [63:0] ifu_rdata_q;
    logic        lsu_rvalid_q;
    logic [63:0] lsu_rdata_q;

    logic        lsu_wins_s;
    logic        ifu_gnt_s;
    logic        lsu_gnt_s;

    // Winner selection and combinational grants; on a tie the port that did not own the last access wins.
    always_comb begin
        lsu_wins_s = 1'b0;
        if (lsu_req_i && ifu_req_i) begin
            lsu_wins_s = (owner_q == OWN_IFU);
        end else begin
            lsu_wins_s = lsu_req_i;
        end
        ifu_gnt_s = (state_q == IDLE) && !rst && ifu_req_i && !lsu_wins_s;
        lsu_gnt_s = (state_q == IDLE) && !rst && lsu_wins_s;
    end

    // Access FSM: latches the winner's fields, drives the memory port, returns data to the owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_IFU;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 64'd0;
            mem_ld_type_q <= 6'd0;
            mem_st_type_q <= 4'd0;
            mem_wdata_q   <= 64'd0;
            ifu_rvalid_q  <= 1'b0;
            ifu_rdata_q   <= 64'd0;
            lsu_rvalid_q  <= 1'b0;
            lsu_rdata_q   <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu_gnt_s) begin
                        state_q       <= BUSY;
                        owner_q       <= OWN_LSU;
                        mem_req_q     <= 1'b1;
                        mem_addr_q    <= lsu_addr_i;
                        mem_ld_type_q <= lsu_ld_type_i;
                        mem_st_type_q <= lsu_st_type_i;
                        mem_wdata_q   <= lsu_wdata_i;
                    end else if (ifu_gnt_s) begin
                        state_q       <= BUSY;
                        owner_q       <= OWN_IFU;
                        mem_req_q     <= 1'b1;
                        mem_addr_q    <= ifu_addr_i;
                        mem_ld_type_q <= 6'b000100;
                        mem_st_type_q <= 4'd0;
                        mem_wdata_q   <= 64'd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        state_q       <= RESP;
                        mem_req_q     <= 1'b0;
                        mem_addr_q    <= 64'd0;
                        mem_ld_type_q <= 6'd0;
                        mem_st_type_q <= 4'd0;
                        mem_wdata_q   <= 64'd0;
                        if (owner_q == OWN_LSU) begin
                            lsu_rvalid_q <= 1'b1;
                            // A pure store returns zero rather than whatever the port drove.
                            lsu_rdata_q  <= (mem_ld_type_q != 6'd0) ? mem_rdata_i : 64'd0;
                        end else begin
                            ifu_rvalid_q <= 1'b1;
                            ifu_rdata_q  <= mem_rdata_i;
                        end
                    end else begin
                        state_q <= BUSY;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    ifu_rvalid_q <= 1'b0;
                    lsu_rvalid_q <= 1'b0;
                end
                default: begin
                    state_q       <= IDLE;
                    mem_req_q     <= 1'b0;
                    mem_addr_q    <= 64'd0;
                    mem_ld_type_q <= 6'd0;
                    mem_st_type_q <= 4'd0;
                    mem_wdata_q   <= 64'd0;
                    ifu_rvalid_q  <= 1'b0;
                    lsu_rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ifu_gnt_o     = ifu_gnt_s;
    assign lsu_gnt_o     = lsu_gnt_s;
    assign ifu_rvalid_o  = ifu_rvalid_q;
    assign ifu_rdata_o   = ifu_rdata_q;
    assign lsu_rvalid_o  = lsu_rvalid_q;
    assign lsu_rdata_o   = lsu_rdata_q;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_ld_type_o = mem_ld_type_q;
    assign mem_st_type_o = mem_st_type_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected responses are queued when mem_ack is driven
// and compared by a monitor whenever an rvalid pulse appears.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic        ifu_gnt_o, ifu_rvalid_o;
    logic [63:0] ifu_rdata_o;
    logic        lsu_req;
    logic [63:0] lsu_addr;
    logic [5:0]  lsu_ld_type;
    logic [3:0]  lsu_st_type;
    logic [63:0] lsu_wdata;
    logic        lsu_gnt_o, lsu_rvalid_o;
    logic [63:0] lsu_rdata_o;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic [5:0]  mem_ld_type_o;
    logic [3:0]  mem_st_type_o;
    logic [63:0] mem_wdata_o;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        lsu;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_i     (ifu_req),
        .ifu_addr_i    (ifu_addr),
        .ifu_gnt_o     (ifu_gnt_o),
        .ifu_rvalid_o  (ifu_rvalid_o),
        .ifu_rdata_o   (ifu_rdata_o),
        .lsu_req_i     (lsu_req),
        .lsu_addr_i    (lsu_addr),
        .lsu_ld_type_i (lsu_ld_type),
        .lsu_st_type_i (lsu_st_type),
        .lsu_wdata_i   (lsu_wdata),
        .lsu_gnt_o     (lsu_gnt_o),
        .lsu_rvalid_o  (lsu_rvalid_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ld_type_o (mem_ld_type_o),
        .mem_st_type_o (mem_st_type_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mem_idle(input string tag);
        check({tag, "_mem_req"},   64'(mem_req_o),     64'd0);
        check({tag, "_mem_addr"},  mem_addr_o,         64'd0);
        check({tag, "_mem_ld"},    64'(mem_ld_type_o), 64'd0);
        check({tag, "_mem_st"},    64'(mem_st_type_o), 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata_o,        64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_mem_idle(tag);
        check({tag, "_gnt"},    64'({ifu_gnt_o, lsu_gnt_o}),       64'd0);
        check({tag, "_rvalid"}, 64'({ifu_rvalid_o, lsu_rvalid_o}), 64'd0);
        check({tag, "_ifu_rd"}, ifu_rdata_o, 64'd0);
        check({tag, "_lsu_rd"}, lsu_rdata_o, 64'd0);
    endtask

    // Entered just after a negedge in IDLE with requests already driven; returns just after the
    // negedge that starts the next IDLE cycle.
    task automatic serve(input logic lsu, input logic [63:0] addr, input logic [5:0] ld,
                         input logic [3:0] st, input logic [63:0] wd, input int delay,
                         input logic [63:0] rd);
        logic [63:0] exp_rd;
        exp_rd = (lsu && ld == 6'd0) ? 64'd0 : rd;
        #1;
        check("ifu_gnt", 64'(ifu_gnt_o), 64'(!lsu));
        check("lsu_gnt", 64'(lsu_gnt_o), 64'(lsu));
        @(negedge clk);
        if (lsu) lsu_req = 1'b0; else ifu_req = 1'b0;
        #1;
        for (int i = 0; i < delay; i++) begin
            check("busy_mem_req",   64'(mem_req_o),     64'd1);
            check("busy_mem_addr",  mem_addr_o,         addr);
            check("busy_mem_ld",    64'(mem_ld_type_o), 64'(ld));
            check("busy_mem_st",    64'(mem_st_type_o), 64'(st));
            check("busy_mem_wdata", mem_wdata_o,        wd);
            check("busy_no_gnt",    64'({ifu_gnt_o, lsu_gnt_o}), 64'd0);
            if (i == delay - 1) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
                sb.push_back('{lsu, exp_rd});
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom};
            #1;
        end
        check_mem_idle("resp");
        check("resp_no_gnt", 64'({ifu_gnt_o, lsu_gnt_o}), 64'd0);
        @(negedge clk);
        #1;
        check("rvalid_seen", 64'(sb.size()), 64'd0);
        check("rvalid_dropped", 64'({ifu_rvalid_o, lsu_rvalid_o}), 64'd0);
        check("rdata_hold", lsu ? lsu_rdata_o : ifu_rdata_o, exp_rd);
        check_mem_idle("after");
    endtask

    // Response monitor: every rvalid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        #3;
        if (ifu_rvalid_o || lsu_rvalid_o) begin
            if (sb.size() == 0) begin
                check("spurious_rvalid", 64'({ifu_rvalid_o, lsu_rvalid_o}), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rv_lsu", 64'(lsu_rvalid_o), 64'(mon_e.lsu));
                check("rv_ifu", 64'(ifu_rvalid_o), 64'(!mon_e.lsu));
                check("rv_data", mon_e.lsu ? lsu_rdata_o : ifu_rdata_o, mon_e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifu_req = 1'b1;
        ifu_addr = 64'h0000_0000_8000_0000;
        lsu_req = 1'b0;
        lsu_addr = 64'd0;
        lsu_ld_type = 6'd0;
        lsu_st_type = 4'd0;
        lsu_wdata = 64'd0;
        mem_ack = 1'b1;
        mem_rdata = 64'h1234_5678_9ABC_DEF0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        ifu_req = 1'b0;
        mem_ack = 1'b0;
        #1;
        check_all_zero("post_reset");

        // Tie after reset: LSU first, then IFU, then alternating.
        @(negedge clk);
        ifu_req = 1'b1; ifu_addr = 64'h0000_0000_8000_0040;
        lsu_req = 1'b1; lsu_addr = 64'h0000_0000_8000_2000;
        lsu_ld_type = 6'b001000; lsu_st_type = 4'd0; lsu_wdata = 64'h1111_2222_3333_4444;
        serve(1'b1, 64'h0000_0000_8000_2000, 6'b001000, 4'd0, 64'h1111_2222_3333_4444, 1, 64'hAAAA_0000_BBBB_0001);
        serve(1'b0, 64'h0000_0000_8000_0040, 6'b000100, 4'd0, 64'd0, 1, 64'h0000_0013_0000_0113);
        ifu_req = 1'b1; ifu_addr = 64'h0000_0000_8000_0048;
        lsu_req = 1'b1; lsu_addr = 64'h0000_0000_8000_2008;
        lsu_ld_type = 6'd0; lsu_st_type = 4'b0010; lsu_wdata = 64'h5555_6666_7777_8888;
        serve(1'b1, 64'h0000_0000_8000_2008, 6'd0, 4'b0010, 64'h5555_6666_7777_8888, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        serve(1'b0, 64'h0000_0000_8000_0048, 6'b000100, 4'd0, 64'd0, 3, 64'h0102_0304_0506_0708);

        // IFU-only fetch with single-cycle ack.
        ifu_req = 1'b1; ifu_addr = 64'h0000_0000_8000_0000;
        serve(1'b0, 64'h0000_0000_8000_0000, 6'b000100, 4'd0, 64'd0, 1, 64'h0000_0013_0000_0093);

        // Doubleword store with a five-cycle memory stall.
        lsu_req = 1'b1; lsu_addr = 64'h0000_0000_8000_1000;
        lsu_ld_type = 6'd0; lsu_st_type = 4'b0001; lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        serve(1'b1, 64'h0000_0000_8000_1000, 6'd0, 4'b0001, 64'hDEAD_BEEF_CAFE_F00D, 5, 64'h0BAD_0BAD_0BAD_0BAD);

        // Spurious ack while idle must be ignored.
        mem_ack = 1'b1; mem_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
        #1;
        check("idle_ack_gnt", 64'({ifu_gnt_o, lsu_gnt_o}), 64'd0);
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check_mem_idle("idle_ack");
        check("idle_ack_lsu_rd", lsu_rdata_o, 64'd0);
        @(negedge clk);
        ifu_req = 1'b1; ifu_addr = 64'h0000_0000_8000_0100;
        serve(1'b0, 64'h0000_0000_8000_0100, 6'b000100, 4'd0, 64'd0, 1, 64'h0000_0000_0000_0073);

        // Long stall with the other port waiting: no grant until the access completes.
        ifu_req = 1'b1; ifu_addr = 64'h0000_0000_8000_0200;
        lsu_req = 1'b1; lsu_addr = 64'h0000_0000_8000_3000;
        lsu_ld_type = 6'b001000; lsu_st_type = 4'd0; lsu_wdata = 64'h9999_9999_9999_9999;
        serve(1'b1, 64'h0000_0000_8000_3000, 6'b001000, 4'd0, 64'h9999_9999_9999_9999, 100, 64'h0000_0000_FFFF_FFFE);
        serve(1'b0, 64'h0000_0000_8000_0200, 6'b000100, 4'd0, 64'd0, 1, 64'h0000_0000_0000_0001);

        // No-op type and multi-hot types pass straight through.
        lsu_req = 1'b1; lsu_addr = 64'h0000_0000_8000_4000;
        lsu_ld_type = 6'd0; lsu_st_type = 4'd0; lsu_wdata = 64'h0000_0000_0000_00AB;
        serve(1'b1, 64'h0000_0000_8000_4000, 6'd0, 4'd0, 64'h0000_0000_0000_00AB, 1, 64'h7777_7777_7777_7777);
        lsu_req = 1'b1; lsu_addr = 64'h0000_0000_8000_4008;
        lsu_ld_type = 6'b100001; lsu_st_type = 4'b1001; lsu_wdata = 64'h0000_0000_0000_00CD;
        serve(1'b1, 64'h0000_0000_8000_4008, 6'b100001, 4'b1001, 64'h0000_0000_0000_00CD, 1, 64'h0123_4567_89AB_CDEF);

        // Reset mid-access: outputs clear at once, a late ack is ignored, round-robin restarts.
        lsu_req = 1'b1; lsu_addr = 64'h0000_0000_8000_5000;
        lsu_ld_type = 6'b000100; lsu_st_type = 4'd0; lsu_wdata = 64'd0;
        #1;
        check("rb_lsu_gnt", 64'(lsu_gnt_o), 64'd1);
        @(negedge clk);
        lsu_req = 1'b0;
        #1;
        check("rb_busy", 64'(mem_req_o), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_busy");
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check_all_zero("rst_late_ack");
        @(negedge clk);
        #1;
        check_all_zero("rst_late_ack2");
        ifu_req = 1'b1; ifu_addr = 64'h0000_0000_8000_0300;
        lsu_req = 1'b1; lsu_addr = 64'h0000_0000_8000_6000;
        lsu_ld_type = 6'b000100; lsu_st_type = 4'd0; lsu_wdata = 64'd0;
        serve(1'b1, 64'h0000_0000_8000_6000, 6'b000100, 4'd0, 64'd0, 1, 64'h1357_9BDF_2468_ACE0);
        serve(1'b0, 64'h0000_0000_8000_0300, 6'b000100, 4'd0, 64'd0, 1, 64'h0000_0000_0000_0013);

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; address and data widths are fixed at 64 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ifu_req  input  1  instruction-fetch read request; held until granted.
REQ-005 ifu_addr  input  64  fetch address; stable while ifu_req is high.
REQ-006 ifu_gnt  output  1  request accepted this cycle.
REQ-007 ifu_rvalid  output  1  one-cycle pulse: ifu_rdata valid.
REQ-008 ifu_rdata  output  64  fetch data (raw 64-bit memory word).
REQ-009 lsu_req  input  1  load/store request; held until granted.
REQ-010 lsu_addr  input  64  load/store address.
REQ-011 lsu_ld_type  input  6  one-hot load type {lb,lh,lw,ld,lbu,lhu}, MSB first; zero means no load.
REQ-012 lsu_st_type  input  4  one-hot store type {sb,sh,sw,sd}, MSB first; zero means no store.
REQ-013 lsu_wdata  input  64  store data.
REQ-014 lsu_gnt  output  1  request accepted this cycle.
REQ-015 lsu_rvalid  output  1  one-cycle pulse: load data valid or store complete.
REQ-016 lsu_rdata  output  64  load data (already extended by the memory port).
REQ-017 mem_req  output  1  shared memory port access active.
REQ-018 mem_addr  output  64  address to the memory port (drives both its read and write address).
REQ-019 mem_ld_type  output  6  load type to the memory port.
REQ-020 mem_st_type  output  4  store type to the memory port.
REQ-021 mem_wdata  output  64  store data to the memory port.
REQ-022 mem_ack  input  1  memory port completes the access this cycle.
REQ-023 mem_rdata  input  64  memory read data; valid when mem_ack is high.

Function
REQ-024 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-025 In IDLE with any request high, the arbiter SHALL pick a winner, assert its gnt combinationally in that cycle, latch its fields, record the owner, and enter BUSY.
REQ-026 Arbitration: a single requester SHALL win; when both request, the requester other than last_owner SHALL win (round-robin); last_owner resets to IFU, so LSU wins the first tie.
REQ-027 An IFU grant SHALL latch ld_type=000100 (ld) and st_type=0000.
REQ-028 In BUSY, mem_req=1 and the mem_* outputs SHALL carry the latched fields, unchanged until exit.
REQ-029 Outside BUSY, mem_req, mem_addr, mem_ld_type, mem_st_type and mem_wdata SHALL all be 0, so that no spurious combinational write occurs.
REQ-030 In BUSY with mem_ack=1, the arbiter SHALL register mem_rdata into the owner's rdata register and enter RESP; BUSY SHALL persist indefinitely without mem_ack.
REQ-031 In RESP, the owner's rvalid SHALL be high for exactly one cycle, then the FSM SHALL enter IDLE; no grant is issued in RESP.
REQ-032 For an LSU store (ld_type=0), lsu_rdata SHALL be 0 at the rvalid pulse.
REQ-033 rdata outputs SHALL hold their last value after rvalid drops.
REQ-034 Latency: request in IDLE at cycle N -> gnt at N, mem_req from N+1, earliest rvalid at N+2 (mem_ack at N+1), next grant at N+3.
REQ-035 mem_ack SHALL be ignored in IDLE and RESP.
REQ-036 A request with both ld_type and st_type zero SHALL still be granted and forwarded; multi-hot types SHALL pass through unchanged.
REQ-037 Requests deasserted before grant SHALL be dropped without side effects.

Reset
REQ-038 On rst: state=IDLE, last_owner=IFU, and all outputs and latched fields =0, asynchronously.
REQ-039 Reset during BUSY or RESP SHALL abort the access with no rvalid pulse; a mem_ack arriving after reset SHALL be ignored.

Verification
REQ-040 IFU only: ifu_req, addr=0x80000000; mem_ack 1 cycle later with rdata=0x00000013_00000093 -> ifu_gnt at N, ifu_rvalid at N+2 with that data, mem_ld_type=000100.
REQ-041 Tie after reset: both request -> LSU granted first, IFU next at N+3; repeat tie -> grants alternate LSU/IFU.
REQ-042 Store: lsu sd, addr=0x80001000, wdata=0xDEADBEEF_CAFEF00D, mem_ack delayed 5 cycles -> mem_st_type=0001 held for 5 cycles, lsu_rvalid with lsu_rdata=0, mem_* =0 afterwards.
REQ-043 Stall: mem_ack withheld 100 cycles -> stays BUSY, no rvalid, no new grants, mem_* outputs stable.
REQ-044 Reset in BUSY: assert rst mid-access, then pulse mem_ack -> all outputs 0, no rvalid, next tie granted to LSU.
REQ-045 Spurious ack: mem_ack=1 in IDLE -> no rvalid, no state change.
